// File: rtl/lab2_rr_arbiter_5bit.sv
// lab2_rr_arbiter_5bit: five-way round-robin arbiter with per-grant hold limit
// Ports: clk, rst (async, active-high); req[4:0] request lines;
//        grant[4:0] registered one-hot grant; A[2:0] granted index; V valid (=|grant).
// MAX_HOLD (1..7) caps consecutive cycles one owner keeps the grant.
module lab2_rr_arbiter_5bit #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  output logic [4:0] grant,
  output logic [2:0] A,
  output logic       V
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;
  logic [2:0] ptr, ptr_nx, hold_cnt, hold_nx, owner, owner_nx, win, idx;
  logic [3:0] sum;
  logic [4:0] elig;
  logic found, keep;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      owner    <= '0;
      grant    <= '0;
      A        <= '0;
      V        <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
      owner    <= owner_nx;
      grant    <= state_nx == GRANT ? 5'd1 << owner_nx : 5'd0;
      A        <= state_nx == GRANT ? owner_nx : 3'd0;
      V        <= state_nx == GRANT;
    end
  // Owner is masked out while granted: on release it is not requesting anyway,
  // and on expiry it must lose to any other requester.
  always_comb begin
    keep  = state == GRANT && req[owner] && hold_cnt < 3'(MAX_HOLD);
    elig  = state == GRANT ? req & ~(5'd1 << owner) : req;
    win   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    // Scan farthest-first so the position nearest ptr is the last to overwrite.
    for (int k = 4; k >= 0; k--) begin
      sum = {1'b0, ptr} + 4'(k);
      idx = sum >= 4'd5 ? 3'(sum - 4'd5) : sum[2:0];
      if (elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    state_nx = state;
    ptr_nx   = ptr;
    hold_nx  = hold_cnt;
    owner_nx = owner;
    if (keep)
      hold_nx = hold_cnt + 3'd1;
    else if (found) begin
      state_nx = GRANT;
      owner_nx = win;
      hold_nx  = 3'd1;
      ptr_nx   = win == 3'd4 ? 3'd0 : win + 3'd1;
    end else if (state == GRANT && req[owner]) begin
      hold_nx = 3'd1;
      ptr_nx  = owner == 3'd4 ? 3'd0 : owner + 3'd1;
    end else
      state_nx = IDLE;
  end
endmodule
